ifu: RTL

Instruction fetch unit for the single-issue pipelined CPU. It holds the program counter, drives the instruction memory's address and enable, and selects the next PC from sequential, branch, jump and register-jump sources. It captures the returned instruction word into the IF/ID pipeline register. It sits directly upstream of the instruction memory and feeds the decode stage.

---
 rtl/ifu.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/ifu.sv
`default_nettype none
// ============================================================================
// Module      : ifu
// Description : Instruction fetch unit. Holds the program counter, drives the
//               instruction memory address/enable, selects the next PC from
//               sequential, branch, jump and register-jump sources, and
//               captures the fetched word into the IF/ID pipeline register.
//               Optional feature macro: IFU_DELAY_SLOT_EN (MIPS delay slot).
// Revision    : 1.0 - initial release
// ============================================================================
module ifu #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        halt_req,
    input  logic [1:0]  npc_sel,
    input  logic [25:0] imm,
    input  logic [31:0] rs_value,
    input  logic [31:0] im_result,
    output logic [31:0] im_addr,
    output logic        im_enable,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic        if_id_valid,
    output logic        misaligned
);

    // Next-PC source encodings
    localparam logic [1:0] c_sel_seq    = 2'd0;
    localparam logic [1:0] c_sel_branch = 2'd1;
    localparam logic [1:0] c_sel_jump   = 2'd2;
    localparam logic [1:0] c_sel_jr     = 2'd3;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_ifpc;
    logic        r_valid;
    logic        r_mis;

    logic [31:0] w_pc_nxt;
    logic [31:0] w_instr_nxt;
    logic [31:0] w_ifpc_nxt;
    logic        w_valid_nxt;
    logic        w_mis_nxt;

    // Target arithmetic (all modulo 2^32)
    logic [31:0] w_pc_plus4;
    logic [31:0] w_ifpc_plus4;
    logic [31:0] w_br_off;
    logic [31:0] w_br_target;
    logic [31:0] w_j_target;
    logic [31:0] w_jr_target;
    logic [31:0] w_target;
    logic        w_redirect;
    logic        w_squash;
    logic        w_jr_mis;

    // Values loaded by a normal (non-stalled, non-halting) fetch edge
    logic [31:0] w_adv_pc;
    logic [31:0] w_adv_instr;
    logic [31:0] w_adv_ifpc;
    logic        w_adv_valid;
    logic        w_adv_mis;

    // Branch/jump targets are relative to the instruction sitting in decode
    assign w_pc_plus4   = r_pc + 32'd4;
    assign w_ifpc_plus4 = r_ifpc + 32'd4;
    assign w_br_off     = {{14{imm[15]}}, imm[15:0], 2'b00};
    assign w_br_target  = w_ifpc_plus4 + w_br_off;
    assign w_j_target   = {w_ifpc_plus4[31:28], imm, 2'b00};
    assign w_jr_target  = {rs_value[31:2], 2'b00};

    // A redirect only counts when decode actually holds an instruction
    assign w_redirect = (npc_sel != c_sel_seq) && r_valid;
    assign w_jr_mis   = w_redirect && (npc_sel == c_sel_jr) && (rs_value[1:0] != 2'b00);

`ifdef IFU_DELAY_SLOT_EN
    // The sequentially fetched word becomes the delay slot and is kept
    assign w_squash = 1'b0;
`else
    // The wrong-path word fetched alongside a taken redirect is dropped
    assign w_squash = w_redirect;
`endif

    // Redirect target selection
    always_comb begin
        w_target = w_pc_plus4;
        case (npc_sel)
            c_sel_branch: w_target = w_br_target;
            c_sel_jump:   w_target = w_j_target;
            c_sel_jr:     w_target = w_jr_target;
            default:      w_target = w_pc_plus4;
        endcase
    end

    // State loaded on an ordinary fetch edge: new PC plus IF/ID capture or bubble
    always_comb begin
        w_adv_pc    = w_redirect ? w_target : w_pc_plus4;
        w_adv_mis   = r_mis | w_jr_mis;
        w_adv_instr = im_result;
        w_adv_ifpc  = r_pc;
        w_adv_valid = 1'b1;
        if (flush || w_squash) begin
            w_adv_instr = 32'd0;
            w_adv_ifpc  = 32'd0;
            w_adv_valid = 1'b0;
        end
    end

    // Next-state and next-register selection; stall beats everything else
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_instr_nxt = r_instr;
        w_ifpc_nxt  = r_ifpc;
        w_valid_nxt = r_valid;
        w_mis_nxt   = r_mis;
        case (r_state)
            ST_BOOT: begin
                w_state_nxt = ST_RUN;
                if (!stall) begin
                    w_pc_nxt    = w_adv_pc;
                    w_instr_nxt = w_adv_instr;
                    w_ifpc_nxt  = w_adv_ifpc;
                    w_valid_nxt = w_adv_valid;
                    w_mis_nxt   = w_adv_mis;
                end
            end
            ST_RUN: begin
                if (!stall) begin
                    if (halt_req) begin
                        // Halt wins over any redirect: PC frozen, bubble in IF/ID
                        w_state_nxt = ST_HALT;
                        w_instr_nxt = 32'd0;
                        w_ifpc_nxt  = 32'd0;
                        w_valid_nxt = 1'b0;
                    end else begin
                        w_pc_nxt    = w_adv_pc;
                        w_instr_nxt = w_adv_instr;
                        w_ifpc_nxt  = w_adv_ifpc;
                        w_valid_nxt = w_adv_valid;
                        w_mis_nxt   = w_adv_mis;
                    end
                end
            end
            ST_HALT: begin
                w_state_nxt = ST_HALT;
                w_instr_nxt = 32'd0;
                w_ifpc_nxt  = 32'd0;
                w_valid_nxt = 1'b0;
            end
            default: begin
                w_state_nxt = ST_HALT;
                w_instr_nxt = 32'd0;
                w_ifpc_nxt  = 32'd0;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // PC, IF/ID pipeline register and sticky misalignment flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc    <= RESET_PC;
            r_instr <= 32'd0;
            r_ifpc  <= 32'd0;
            r_valid <= 1'b0;
            r_mis   <= 1'b0;
        end else begin
            r_pc    <= w_pc_nxt;
            r_instr <= w_instr_nxt;
            r_ifpc  <= w_ifpc_nxt;
            r_valid <= w_valid_nxt;
            r_mis   <= w_mis_nxt;
        end
    end

    assign im_addr     = r_pc;
    assign im_enable   = (r_state != ST_HALT);
    assign if_id_instr = r_instr;
    assign if_id_pc    = r_ifpc;
    assign if_id_valid = r_valid;
    assign misaligned  = r_mis;

endmodule
`default_nettype wire
